demux_vc: RTL and testbench

//  Destination-side demultiplexer, the inverse of the VC0/VC1 output mux: takes one

---
 rtl/demux_vc_pkg.sv | 17 +
 rtl/demux_vc_buffer.sv | 75 +++++++
 rtl/demux_vc.sv | 66 ++++++
 tb/tb_demux_vc.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_vc_pkg.sv
// Shared types and constants for the demux_vc VC demultiplexer.
// Optional statistics counters are enabled by defining DEMUX_VC_STATS_EN.
package demux_vc_pkg;

  localparam int unsigned BITNUMBER_DEF = 5;
  localparam int unsigned STATS_W       = 8;

  localparam logic VC_0 = 1'b0;
  localparam logic VC_1 = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } occ_t;

endpackage

// File: rtl/demux_vc_buffer.sv
// Per-channel 2-entry holding buffer with occupancy FSM and a registered,
// pausable output stage. Strobe counter present when DEMUX_VC_STATS_EN is defined.
module demux_vc_buffer
  import demux_vc_pkg::*;
#(
  parameter int unsigned W = BITNUMBER_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [W-1:0]       din,
  input  logic               pause,
  output logic               full_c,
  output logic               valid_out,
`ifdef DEMUX_VC_STATS_EN
  output logic [STATS_W-1:0] cnt,
`endif
  output logic [W-1:0]       data_out
);

  occ_t         state;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         pop;

  assign full_c = (state == ST_FULL);
  assign pop    = (state != ST_EMPTY) && !pause;

  // Occupancy FSM; head always holds the oldest entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      head      <= '0;
      tail      <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= pop;
      if (pop) data_out <= head;
      case (state)
        ST_EMPTY: begin
          if (push) begin
            head  <= din;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (pop) begin
            if (push) head <= din;
            else      state <= ST_EMPTY;
          end else if (push) begin
            tail  <= din;
            state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head  <= tail;
            state <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

`ifdef DEMUX_VC_STATS_EN
  // Counts output strobes, wrapping naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (pop) cnt <= cnt + STATS_W'(1);
  end
`endif

endmodule

// File: rtl/demux_vc.sv
// Destination-side demultiplexer steering words to VC0/VC1 by their class bit.
// Define DEMUX_VC_STATS_EN to add cnt_vc0/cnt_vc1 strobe counters.
module demux_vc
  import demux_vc_pkg::*;
#(
  parameter int unsigned BITNUMBER = BITNUMBER_DEF,
  parameter int unsigned SEL_BIT   = BITNUMBER - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [BITNUMBER-1:0] data_in,
  output logic                 ready_in,
  input  logic                 pause_vc0,
  input  logic                 pause_vc1,
  output logic                 valid_out_vc0,
  output logic [BITNUMBER-1:0] data_out_vc0,
  output logic                 valid_out_vc1,
`ifdef DEMUX_VC_STATS_EN
  output logic [STATS_W-1:0]   cnt_vc0,
  output logic [STATS_W-1:0]   cnt_vc1,
`endif
  output logic [BITNUMBER-1:0] data_out_vc1
);

  logic sel;
  logic full_vc0;
  logic full_vc1;
  logic push_vc0;
  logic push_vc1;

  // A full target refuses even if it drains this cycle
  assign sel      = data_in[SEL_BIT];
  assign ready_in = reset && ((sel == VC_1) ? !full_vc1 : !full_vc0);
  assign push_vc0 = valid_in && ready_in && (sel == VC_0);
  assign push_vc1 = valid_in && ready_in && (sel == VC_1);

  demux_vc_buffer #(.W(BITNUMBER)) u_vc0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push_vc0),
    .din       (data_in),
    .pause     (pause_vc0),
    .full_c    (full_vc0),
    .valid_out (valid_out_vc0),
`ifdef DEMUX_VC_STATS_EN
    .cnt       (cnt_vc0),
`endif
    .data_out  (data_out_vc0)
  );

  demux_vc_buffer #(.W(BITNUMBER)) u_vc1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push_vc1),
    .din       (data_in),
    .pause     (pause_vc1),
    .full_c    (full_vc1),
    .valid_out (valid_out_vc1),
`ifdef DEMUX_VC_STATS_EN
    .cnt       (cnt_vc1),
`endif
    .data_out  (data_out_vc1)
  );

endmodule

// File: tb/tb_demux_vc.sv
// Self-checking bench for demux_vc: directed scenarios plus random traffic
// checked against a queue-based model of the two channels.
module tb_demux_vc;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [4:0] data_in;
  logic       ready_in;
  logic       pause_vc0;
  logic       pause_vc1;
  logic       valid_out_vc0;
  logic [4:0] data_out_vc0;
  logic       valid_out_vc1;
  logic [4:0] data_out_vc1;
`ifdef DEMUX_VC_STATS_EN
  logic [7:0] cnt_vc0;
  logic [7:0] cnt_vc1;
`endif

  demux_vc dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .ready_in      (ready_in),
    .pause_vc0     (pause_vc0),
    .pause_vc1     (pause_vc1),
    .valid_out_vc0 (valid_out_vc0),
    .data_out_vc0  (data_out_vc0),
    .valid_out_vc1 (valid_out_vc1),
`ifdef DEMUX_VC_STATS_EN
    .cnt_vc0       (cnt_vc0),
    .cnt_vc1       (cnt_vc1),
`endif
    .data_out_vc1  (data_out_vc1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: one FIFO of capacity 2 per channel plus expected outputs
  logic [4:0] q0[$];
  logic [4:0] q1[$];
  logic       ev0, ev1;
  logic [4:0] ed0, ed1;
  int         n0, n1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    ev0 = 1'b0; ev1 = 1'b0;
    ed0 = 5'h00; ed1 = 5'h00;
    n0 = 0; n1 = 0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ":valid_vc0"}, 32'(valid_out_vc0), 32'(ev0));
    chk({tag, ":data_vc0"},  32'(data_out_vc0),  32'(ed0));
    chk({tag, ":valid_vc1"}, 32'(valid_out_vc1), 32'(ev1));
    chk({tag, ":data_vc1"},  32'(data_out_vc1),  32'(ed1));
`ifdef DEMUX_VC_STATS_EN
    chk({tag, ":cnt_vc0"}, 32'(cnt_vc0), 32'(n0 % 256));
    chk({tag, ":cnt_vc1"}, 32'(cnt_vc1), 32'(n1 % 256));
`endif
  endtask

  // One clock cycle: drive, check ready, advance model, check outputs
  task automatic step(input string tag, input logic v, input logic [4:0] d,
                      input logic p0, input logic p1, output logic acc);
    logic rdy;
    valid_in  = v;
    data_in   = d;
    pause_vc0 = p0;
    pause_vc1 = p1;
    #1;
    rdy = d[4] ? (q1.size() < 2) : (q0.size() < 2);
    chk({tag, ":ready_in"}, 32'(ready_in), 32'(rdy));
    acc = v && rdy;
    @(posedge clk);
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (q0.size() > 0 && !p0) begin ev0 = 1'b1; ed0 = q0.pop_front(); n0++; end
    if (q1.size() > 0 && !p1) begin ev1 = 1'b1; ed1 = q1.pop_front(); n1++; end
    if (acc) begin
      if (d[4]) q1.push_back(d);
      else      q0.push_back(d);
    end
    #1;
    chk_outs(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    valid_in = 1'b0;
    #1;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    logic [4:0] w;
    logic [4:0] seq3[3];

    // Reset held with valid_in high: nothing accepted, outputs cleared
    reset = 1'b0; valid_in = 1'b1; data_in = 5'h03; pause_vc0 = 1'b0; pause_vc1 = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst:ready_in", 32'(ready_in), 32'd0);
    chk_outs("rst");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel:ready_in", 32'(ready_in), 32'd1);
    valid_in = 1'b0;
    @(posedge clk);
    #1;

    // Interleaved VC0/VC1 words, no pause
    step("t2a", 1'b1, 5'h03, 1'b0, 1'b0, acc);
    step("t2b", 1'b1, 5'h13, 1'b0, 1'b0, acc);
    step("t2c", 1'b1, 5'h05, 1'b0, 1'b0, acc);
    step("t2d", 1'b0, 5'h00, 1'b0, 1'b0, acc);
    step("t2e", 1'b0, 5'h00, 1'b0, 1'b0, acc);

    // VC0 paused: two words buffered, third stalls; VC1 keeps flowing
    seq3[0] = 5'h01; seq3[1] = 5'h02; seq3[2] = 5'h04;
    step("t3a", 1'b1, seq3[0], 1'b1, 1'b0, acc);
    step("t3b", 1'b1, seq3[1], 1'b1, 1'b0, acc);
    step("t3c", 1'b1, seq3[2], 1'b1, 1'b0, acc);
    chk("t3c:stall", 32'(acc), 32'd0);
    step("t3d", 1'b1, 5'h11, 1'b1, 1'b0, acc);
    chk("t3d:vc1_accept", 32'(acc), 32'd1);
    step("t3e", 1'b1, seq3[2], 1'b1, 1'b0, acc);
    chk("t3e:still_stall", 32'(acc), 32'd0);
    for (int i = 0; i < 4 && !acc; i++) step("t3f", 1'b1, seq3[2], 1'b0, 1'b0, acc);
    chk("t3f:accepted", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) step("t3g", 1'b0, 5'h00, 1'b0, 1'b0, acc);

    // Back-to-back VC1 words: push and pop in the same cycle
    for (int i = 0; i < 5; i++) step("t4", 1'b1, 5'(5'h18 + i), 1'b0, 1'b0, acc);
    step("t4z", 1'b0, 5'h00, 1'b0, 1'b0, acc);

    // Fill both buffers under pause, then reset mid-cycle
    step("t5a", 1'b1, 5'h0a, 1'b1, 1'b1, acc);
    step("t5b", 1'b1, 5'h1a, 1'b1, 1'b1, acc);
    step("t5c", 1'b1, 5'h0b, 1'b1, 1'b1, acc);
    step("t5d", 1'b1, 5'h1b, 1'b1, 1'b1, acc);
    valid_in = 1'b0;
    reset = 1'b0;
    #1;
    model_clear();
    chk("t5:rst_ready", 32'(ready_in), 32'd0);
    chk_outs("t5rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step("t5e", 1'b0, 5'h00, 1'b0, 1'b0, acc);

    // Random traffic with random pauses
    for (int i = 0; i < 600; i++) begin
      w = 5'($urandom);
      step("rnd", ($urandom_range(0, 3) != 0), w,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), acc);
    end
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 5'h00, 1'b0, 1'b0, acc);

`ifdef DEMUX_VC_STATS_EN
    // 300 VC0 strobes wrap the 8-bit counter to 44
    do_reset();
    for (int i = 0; i < 300; i++) step("st", 1'b1, 5'(i % 16), 1'b0, 1'b0, acc);
    step("st_end", 1'b0, 5'h00, 1'b0, 1'b0, acc);
    chk("st:cnt_vc0_300", 32'(cnt_vc0), 32'd44);
    chk("st:cnt_vc1_0", 32'(cnt_vc1), 32'd0);
`else
    do_reset();
    chk_outs("final_rst");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
